byte_mem_arbiter: RTL and testbench
===================================

// Module: byte_mem_arbiter
// PURPOSE
//  Shares the single-port, byte-wide program/data memory between two requesters: the CPU
//  (instruction fetch and load/store) and the program loader (debug/boot image writer).
//  Sits between the cpu/loader and the memory array, one access per cycle, registered issue,
//  fixed CPU priority with loader anti-starvation aging and a loader-only program mode.
// PARAMETERS
//  ADDR_W        10  byte address width (1024-byte memory)
//  STARVE_LIMIT  4   cycles a blocked loader request waits before it beats a CPU request
// PORTS
//  clk           in   1       single clock, all state on posedge
//  reset         in   1       synchronous, active-high
//  prog_mode     in   1       1: CPU requests ignored, loader only
//  cpu_req       in   1       CPU access request, held with fields until cpu_gnt
//  cpu_we        in   1       1 write, 0 read
//  cpu_addr      in   ADDR_W  byte address
//  cpu_wdata     in   8       write byte
//  cpu_gnt       out  1       1-cycle pulse: access issued to memory this cycle
//  cpu_rvalid    out  1       1-cycle pulse: cpu_rdata valid (reads only)
//  cpu_rdata     out  8       read byte
//  ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_gnt/ldr_rvalid/ldr_rdata: same as cpu_*, loader side
//  mem_en        out  1       memory access this cycle
//  mem_we        out  1       write strobe (only with mem_en)
//  mem_addr      out  ADDR_W  registered address
//  mem_wdata     out  8       registered write byte
//  mem_rdata     in   8       synchronous read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  Reset: state IDLE; all gnt, rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0;
//   ldr_age = 0; pending-read owner cleared.
//  State = owner of memory port this cycle: IDLE, ISSUE_CPU, ISSUE_LDR.
//  Decision at each posedge, from sampled inputs:
//   - cpu eligible = cpu_req & !prog_mode & !(state==ISSUE_CPU)
//   - ldr eligible = ldr_req & !(state==ISSUE_LDR)
//   - requester whose gnt is high this cycle is masked (no back-to-back to same requester)
//   - both eligible: ISSUE_LDR if ldr_age >= STARVE_LIMIT, else ISSUE_CPU
//   - one eligible: that one; none: IDLE
//  On issue, we/addr/wdata of the winner are registered onto mem_*; mem_en=1 and the
//   winner's gnt=1 for exactly that cycle. Latency req sampled -> gnt = 1 cycle.
//  Read return: cycle after an issued read, owner's rvalid=1, rdata=mem_rdata (registered
//   owner tag). Latency gnt -> rvalid = 1 cycle. Writes produce no rvalid.
//  ldr_age: +1 each cycle ldr eligible but not chosen, saturating at STARVE_LIMIT;
//   cleared to 0 when ISSUE_LDR entered or ldr_req low.
//  Throughput: one access/cycle when both requesters busy (alternation); one per 2 cycles
//   for a single requester.
//  prog_mode rising with CPU access issued: that access and its rvalid complete; no new CPU
//   issue while prog_mode=1. Pending CPU req stays pending, served after prog_mode falls.
//  cpu_req dropped before gnt: request withdrawn, no access. Field changes before gnt: legal,
//   value sampled at the issuing edge is used.
//  reset mid-access: in-flight read's rvalid suppressed; memory contents untouched.
//  Address width fixed ADDR_W, no wrap/bounds check (caller sizes memory to 2**ADDR_W).
// STRUCTURE
//  mem_arb_pkg: state encoding (IDLE/ISSUE_CPU/ISSUE_LDR), owner id constants (OWN_CPU,
//   OWN_LDR), STARVE_LIMIT default.
//  Flat module; one natural sub-module: arb_age_counter (saturating counter, clr/inc/sat).
// TESTING
//  1 CPU read only, addr 0x010 holding 0xA5 -> gnt at t+1, cpu_rvalid t+2, cpu_rdata=0xA5.
//  2 Loader writes 0x3C@0x020 while CPU idle, then CPU reads 0x020 -> mem_we once, read=0x3C.
//  3 Both req continuously (reads) -> strict alternation CPU,LDR,CPU,... mem_en every cycle.
//  4 CPU req every eligible cycle, loader held, STARVE_LIMIT=4 -> ldr_gnt within 5 cycles of
//    first eligible cycle, ldr_age returns to 0.
//  5 prog_mode=1 during CPU read issue -> that rvalid delivered, no further cpu_gnt while
//    prog_mode=1; loader writes 0x000..0x00F all granted; prog_mode=0 -> cpu_gnt next cycle.
//  6 reset asserted cycle after a read issue -> no rvalid, all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// mem_arb_pkg : shared types for the byte-memory arbiter. Rev 1.0
// ==========================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE_CPU = 2'd1,
      ISSUE_LDR = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

   // Width needed to hold 0..lim inclusive.
   function automatic int unsigned age_width(input int unsigned lim);
      return (lim < 1) ? 1 : $clog2(lim + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_age_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// arb_age_counter : saturating wait counter with clear priority. Rev 1.0
// ==========================================================================
module arb_age_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned W     = age_width(LIMIT)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   assign sat = (count >= LIMIT_V);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/byte_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// byte_mem_arbiter : CPU/loader share of a single-port byte memory. Rev 1.0
// ==========================================================================
module byte_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_mode,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [7:0]        cpu_rdata,

   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [7:0]        ldr_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int unsigned AGE_W = age_width(STARVE_LIMIT);

   arb_state_t       state;
   arb_state_t       nxt;
   logic             cpu_elig;
   logic             ldr_elig;
   logic [AGE_W-1:0] ldr_age;
   logic             age_sat;
   logic             age_clr;
   logic             age_inc;
   logic             rd_pend;
   owner_t           rd_owner;

   // The current owner is masked, which also yields the no-back-to-back rule.
   assign cpu_elig = cpu_req && !prog_mode && (state != ISSUE_CPU);
   assign ldr_elig = ldr_req && (state != ISSUE_LDR);

   always_comb begin
      nxt = IDLE;
      if (cpu_elig && ldr_elig) begin
         nxt = age_sat ? ISSUE_LDR : ISSUE_CPU;
      end else if (cpu_elig) begin
         nxt = ISSUE_CPU;
      end else if (ldr_elig) begin
         nxt = ISSUE_LDR;
      end
   end

   assign age_clr = (nxt == ISSUE_LDR) || !ldr_req;
   assign age_inc = ldr_elig && (nxt != ISSUE_LDR);

   arb_age_counter #(
      .LIMIT (STARVE_LIMIT),
      .W     (AGE_W)
   ) u_age (
      .clk   (clk),
      .reset (reset),
      .clr   (age_clr),
      .inc   (age_inc),
      .count (ldr_age),
      .sat   (age_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cpu_gnt   <= 1'b0;
         ldr_gnt   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_pend   <= 1'b0;
         rd_owner  <= OWN_CPU;
      end else begin
         state   <= nxt;
         cpu_gnt <= (nxt == ISSUE_CPU);
         ldr_gnt <= (nxt == ISSUE_LDR);
         mem_en  <= (nxt != IDLE);
         case (nxt)
            ISSUE_CPU: begin
               mem_we    <= cpu_we;
               mem_addr  <= cpu_addr;
               mem_wdata <= cpu_wdata;
            end
            ISSUE_LDR: begin
               mem_we    <= ldr_we;
               mem_addr  <= ldr_addr;
               mem_wdata <= ldr_wdata;
            end
            default: begin
               mem_we <= 1'b0;
            end
         endcase
         // Tag the read issued this cycle; memory returns it next cycle.
         rd_pend  <= mem_en && !mem_we;
         rd_owner <= (state == ISSUE_LDR) ? OWN_LDR : OWN_CPU;
      end
   end

   assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
   assign ldr_rvalid = rd_pend && (rd_owner == OWN_LDR);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : 8'h00;
   assign ldr_rdata  = ldr_rvalid ? mem_rdata : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_byte_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_byte_mem_arbiter : directed-vector bench with a behavioural memory. Rev 1.0
// ==========================================================================
module tb_byte_mem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       prog_mode;
   logic       cpu_req, cpu_we;
   logic [9:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_gnt, cpu_rvalid;
   logic [7:0] cpu_rdata;
   logic       ldr_req, ldr_we;
   logic [9:0] ldr_addr;
   logic [7:0] ldr_wdata;
   logic       ldr_gnt, ldr_rvalid;
   logic [7:0] ldr_rdata;
   logic       mem_en, mem_we;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [7:0] mem [0:1023];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   byte_mem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .prog_mode  (prog_mode),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ldr_req    (ldr_req),
      .ldr_we     (ldr_we),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_gnt    (ldr_gnt),
      .ldr_rvalid (ldr_rvalid),
      .ldr_rdata  (ldr_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".cpu_gnt"}, cpu_gnt, 0);
      chk({tag, ".ldr_gnt"}, ldr_gnt, 0);
      chk({tag, ".mem_en"},  mem_en,  0);
   endtask

   initial begin
      bit got;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h010] = 8'hA5;
      mem_rdata = 8'h00;
      reset = 1'b1; prog_mode = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      repeat (3) step();

      // Reset state
      chk_idle("rst");
      chk("rst.mem_we",     mem_we,     0);
      chk("rst.mem_addr",   mem_addr,   0);
      chk("rst.mem_wdata",  mem_wdata,  0);
      chk("rst.cpu_rvalid", cpu_rvalid, 0);
      chk("rst.ldr_rvalid", ldr_rvalid, 0);
      chk("rst.cpu_rdata",  cpu_rdata,  0);
      reset = 1'b0;
      step();

      // 1: single CPU read of 0x010
      cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
      step();
      chk("t1.cpu_gnt",  cpu_gnt,  1);
      chk("t1.mem_en",   mem_en,   1);
      chk("t1.mem_we",   mem_we,   0);
      chk("t1.mem_addr", mem_addr, 10'h010);
      cpu_req = 0;
      step();
      chk("t1.cpu_rvalid", cpu_rvalid, 1);
      chk("t1.cpu_rdata",  cpu_rdata,  8'hA5);
      chk("t1.gnt_drop",   cpu_gnt,    0);
      step();
      chk("t1.rvalid_drop", cpu_rvalid, 0);

      // 2: loader write then CPU read-back
      ldr_req = 1; ldr_we = 1; ldr_addr = 10'h020; ldr_wdata = 8'h3C;
      step();
      chk("t2.ldr_gnt",   ldr_gnt,   1);
      chk("t2.mem_we",    mem_we,    1);
      chk("t2.mem_addr",  mem_addr,  10'h020);
      chk("t2.mem_wdata", mem_wdata, 8'h3C);
      ldr_req = 0;
      step();
      chk("t2.ldr_rvalid", ldr_rvalid, 0);
      chk("t2.we_once",    mem_we,     0);
      cpu_req = 1; cpu_we = 0; cpu_addr = 10'h020;
      step();
      chk("t2.cpu_gnt", cpu_gnt, 1);
      cpu_req = 0;
      step();
      chk("t2.cpu_rvalid", cpu_rvalid, 1);
      chk("t2.cpu_rdata",  cpu_rdata,  8'h3C);
      step();

      // 3: both continuously reading -> alternation CPU, LDR, ...
      cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
      ldr_req = 1; ldr_we = 0; ldr_addr = 10'h020;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("t3.cpu_gnt[%0d]", k), cpu_gnt, (k % 2 == 0));
         chk($sformatf("t3.ldr_gnt[%0d]", k), ldr_gnt, (k % 2 == 1));
         chk($sformatf("t3.mem_en[%0d]",  k), mem_en,  1);
         if (k > 0) begin
            chk($sformatf("t3.cpu_rvalid[%0d]", k), cpu_rvalid, (k % 2 == 1));
            chk($sformatf("t3.ldr_rvalid[%0d]", k), ldr_rvalid, (k % 2 == 0));
            chk($sformatf("t3.rdata[%0d]", k), (k % 2 == 1) ? cpu_rdata : ldr_rdata,
                (k % 2 == 1) ? 8'hA5 : 8'h3C);
         end
      end
      cpu_req = 0; ldr_req = 0;
      step();
      chk("t3.tail_ldr_rvalid", ldr_rvalid, 1);
      chk_idle("t3.tail");
      step();

      // 4: loader held against a CPU requesting every eligible cycle
      cpu_req = 1; ldr_req = 1;
      step();
      chk("t4.cpu_gnt", cpu_gnt, 1);
      chk("t4.age1",    dut.ldr_age, 1);
      step();
      chk("t4.ldr_gnt", ldr_gnt, 1);
      chk("t4.age0",    dut.ldr_age, 0);
      ldr_req = 0;
      step();
      chk("t4.cpu_gnt2",    cpu_gnt,    1);
      chk("t4.ldr_rvalid",  ldr_rvalid, 1);
      cpu_req = 0;
      step();
      chk("t4.cpu_rvalid", cpu_rvalid, 1);
      step();
      chk_idle("t4.end");

      // 5: prog_mode raised while a CPU read is in flight
      cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
      step();
      chk("t5.cpu_gnt", cpu_gnt, 1);
      prog_mode = 1; cpu_addr = 10'h005;
      step();
      chk("t5.cpu_rvalid", cpu_rvalid, 1);
      chk("t5.cpu_rdata",  cpu_rdata,  8'hA5);
      chk("t5.no_gnt",     cpu_gnt,    0);
      for (int i = 0; i < 16; i++) begin
         ldr_req = 1; ldr_we = 1; ldr_addr = 10'(i); ldr_wdata = 8'h80 + 8'(i);
         got = 0;
         for (int c = 0; c < 4 && !got; c++) begin
            step();
            chk($sformatf("t5.cpu_blocked[%0d]", i), cpu_gnt, 0);
            if (ldr_gnt) begin
               got = 1;
               chk($sformatf("t5.waddr[%0d]", i), mem_addr,  10'(i));
               chk($sformatf("t5.wdata[%0d]", i), mem_wdata, 8'h80 + 8'(i));
               chk($sformatf("t5.we[%0d]", i),    mem_we,    1);
            end
         end
         chk($sformatf("t5.ldr_granted[%0d]", i), got, 1);
      end
      ldr_req = 0; prog_mode = 0;
      step();
      chk("t5.cpu_resume", cpu_gnt,  1);
      chk("t5.resume_addr", mem_addr, 10'h005);
      cpu_req = 0;
      step();
      chk("t5.resume_rvalid", cpu_rvalid, 1);
      chk("t5.resume_rdata",  cpu_rdata,  8'h85);
      step();

      // 6: reset right behind a read issue
      cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
      step();
      chk("t6.cpu_gnt", cpu_gnt, 1);
      cpu_req = 0; reset = 1;
      step();
      chk("t6.cpu_rvalid", cpu_rvalid, 0);
      chk("t6.cpu_rdata",  cpu_rdata,  0);
      chk_idle("t6.rst");
      chk("t6.mem_addr",   mem_addr,   0);
      chk("t6.mem_we",     mem_we,     0);
      reset = 0;
      step();
      cpu_req = 1; cpu_addr = 10'h020;
      step();
      chk("t6.post_gnt", cpu_gnt, 1);
      cpu_req = 0;
      step();
      chk("t6.post_rdata", cpu_rdata, 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
